// File: rtl/float_exp_interp_pipe.sv
// float_exp_interp_pipe: six-stage streaming IEEE-754 exp(x) unit.
// exp(x) = 2^(x*log2e). The integer part of the product becomes the result
// exponent. The fraction indexes a 2^f table with linear interpolation.
// Optional build macro FLOAT_EXP_FLAGS_EN adds a flags[2:0] port carrying
// {invalid, overflow, underflow}, registered alongside c.
module float_exp_interp_pipe #(
    parameter int  EXP_BITS  = 8,
    parameter int  MAN_BITS  = 23,
    parameter int  STEPS     = 64,
    parameter real LIMIT     = 8.0,
    parameter int  FRAC_BITS = 28
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_BITS+MAN_BITS:0]     a,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_BITS+MAN_BITS:0]     c
`ifdef FLOAT_EXP_FLAGS_EN
    ,
    output logic [2:0]                     flags
`endif
);
    localparam int FW   = 1 + EXP_BITS + MAN_BITS;
    localparam int KW   = 6;                    // signed integer bits of x and y; LIMIT must stay below 16
    localparam int W    = FRAC_BITS + KW;       // signed fixed-point width of x and y
    localparam int MW   = MAN_BITS + 1;         // mantissa including hidden bit
    localparam int XW   = MW + W;               // unpack scratch width
    localparam int IB   = $clog2(STEPS);
    localparam int RB   = FRAC_BITS - IB;
    localparam int TW   = MAN_BITS + 2;         // table entries hold 2.0 with one extra integer bit
    localparam int CW   = FRAC_BITS + 4;        // signed width of the log2e constant
    localparam int EW   = EXP_BITS + 2;
    localparam int BIAS = 2 ** (EXP_BITS - 1) - 1;

    localparam longint LIMIT_FIX = longint'(LIMIT * (2.0 ** FRAC_BITS));
    localparam longint LOG2E_FIX = longint'(1.4426950408889634 * (2.0 ** (FRAC_BITS + 2)));
    localparam logic signed [CW-1:0] LOG2E_C = CW'(LOG2E_FIX);
    localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_E  = EW'(2 ** EXP_BITS - 1);
    localparam logic [FW-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};
    localparam logic [FW-1:0] PINF = {1'b0, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};

    // Special-case tags. Overflow/underflow sources are kept apart from
    // infinite inputs so the flag logic can tell them apart.
    typedef enum logic [2:0] {
        SP_NONE, SP_NAN, SP_INF_IN, SP_OVF, SP_ZERO_IN, SP_UNF
    } sp_e;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // 2^(j/STEPS) table, entries fixed at elaboration.
    logic [TW-1:0] table_rom [0:STEPS];
    for (genvar j = 0; j <= STEPS; j++) begin : g_table
        localparam longint TV = longint'($pow(2.0, real'(j) / real'(STEPS)) * (2.0 ** MAN_BITS));
        assign table_rom[j] = TW'(TV);
    end

    // Stage registers
    logic                  v1, v2, v3, v4, v5;
    sp_e                   sp1, sp2, sp3, sp4, sp5;
    logic signed [W-1:0]   x1, y2;
    logic signed [KW-1:0]  k3, k4, k5;
    logic [IB-1:0]         i3;
    logic [RB-1:0]         r3, r4;
    logic [TW-1:0]         t0_4, t1_4, m5;

    // S1: classify and convert to signed fixed point, truncating toward zero.
    logic                  a_sign;
    logic [EXP_BITS-1:0]   a_exp;
    logic [MAN_BITS-1:0]   a_man;
    int                    unbiased, sh;
    logic [XW-1:0]         mag;
    logic signed [W-1:0]   x_fix;
    sp_e                   x_sp;
    assign {a_sign, a_exp, a_man} = a;

    // Unpack: specials, tiny/subnormal to zero, range check against LIMIT.
    // NOTE: every signal written here is given a default first so no latch is inferred.
    always_comb begin
        x_sp     = SP_NONE;
        x_fix    = '0;
        mag      = '0;
        unbiased = int'({1'b0, a_exp}) - BIAS;
        sh       = unbiased + FRAC_BITS - MAN_BITS;
        if (a_exp == '1) begin
            if (a_man != '0)  x_sp = SP_NAN;
            else if (a_sign)  x_sp = SP_ZERO_IN;
            else              x_sp = SP_INF_IN;
        end else if (a_exp == '0 || unbiased < -FRAC_BITS) begin
            x_fix = '0;
        end else if (unbiased >= KW - 2) begin
            x_sp = a_sign ? SP_UNF : SP_OVF;
        end else begin
            mag = XW'({1'b1, a_man});
            mag = (sh >= 0) ? (mag << sh) : (mag >> (-sh));
            if (mag > XW'(LIMIT_FIX))
                x_sp = a_sign ? SP_UNF : SP_OVF;
            else
                x_fix = a_sign ? -$signed(mag[W-1:0]) : $signed(mag[W-1:0]);
        end
    end

    // S2: y = x * log2e, truncated back to FRAC_BITS fraction bits.
    logic signed [W+CW-1:0] prod2;
    logic signed [W-1:0]    y_next;
    assign prod2  = x1 * LOG2E_C;
    assign y_next = W'(prod2 >>> (FRAC_BITS + 2));

    // S4: table lookup of both segment endpoints.
    logic [IB:0] i_lo, i_hi;
    assign i_lo = (IB+1)'(i3);
    assign i_hi = (IB+1)'(i3) + (IB+1)'(1);

    // S5: linear interpolation inside the segment, clamped below 2.0.
    logic [TW-1:0]    diff5, m_next;
    logic [TW+RB-1:0] prod5;
    always_comb begin
        diff5  = t1_4 - t0_4;
        prod5  = diff5 * r4;
        m_next = t0_4 + TW'(prod5 >> RB);
        if (m_next[TW-1])
            m_next = {1'b0, {(TW-1){1'b1}}};
    end

    // S6: exponent rebias, range clamp and special bypass.
    logic signed [EW-1:0] e_val;
    logic [FW-1:0]        c_next;
`ifdef FLOAT_EXP_FLAGS_EN
    logic [2:0]           flags_next;
`endif
    always_comb begin
        e_val  = EW'(k5) + BIAS_E;
        c_next = '0;
        case (sp5)
            SP_NAN:              c_next = QNAN;
            SP_INF_IN, SP_OVF:   c_next = PINF;
            SP_ZERO_IN, SP_UNF:  c_next = '0;
            default: begin
                if (e_val <= 0)           c_next = '0;
                else if (e_val >= EMAX_E) c_next = PINF;
                else                      c_next = {1'b0, e_val[EXP_BITS-1:0], m5[MAN_BITS-1:0]};
            end
        endcase
`ifdef FLOAT_EXP_FLAGS_EN
        flags_next    = '0;
        flags_next[2] = (sp5 == SP_NAN);
        flags_next[1] = (sp5 == SP_OVF) || (sp5 == SP_NONE && e_val >= EMAX_E);
        flags_next[0] = (sp5 == SP_UNF) || (sp5 == SP_NONE && e_val <= 0);
`endif
    end

    // Valid bits: cleared by reset, advance together when the output is free.
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0; v5 <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid && in_ready;
            v2 <= v1; v3 <= v2; v4 <= v3; v5 <= v4;
            out_valid <= v5;
        end
    end

    // Datapath registers: qualified by the valid bits, so they carry no reset.
    // NOTE: leaving payload registers unreset is safe because nothing reads them while their valid bit is 0.
    always_ff @(posedge clk) begin
        if (adv) begin
            sp1  <= x_sp;  x1 <= x_fix;
            sp2  <= sp1;   y2 <= y_next;
            sp3  <= sp2;   k3 <= y2[W-1:FRAC_BITS];
            i3   <= y2[FRAC_BITS-1 -: IB];
            r3   <= y2[RB-1:0];
            sp4  <= sp3;   k4 <= k3;  r4 <= r3;
            t0_4 <= table_rom[i_lo];
            t1_4 <= table_rom[i_hi];
            sp5  <= sp4;   k5 <= k4;  m5 <= m_next;
        end
    end

    // Output register: reset to 0, loaded only from a valid stage-5 item.
    always_ff @(posedge clk) begin
        if (!rst_n)
            c <= '0;
        else if (adv && v5)
            c <= c_next;
    end

`ifdef FLOAT_EXP_FLAGS_EN
    // Flags follow c, and read 0 whenever no result is presented.
    always_ff @(posedge clk) begin
        if (!rst_n)
            flags <= '0;
        else if (adv)
            flags <= v5 ? flags_next : 3'b000;
    end
`endif

endmodule

// File: tb/tb_float_exp_interp_pipe.sv
// Scoreboard bench for float_exp_interp_pipe: a single-precision instance with
// directed vectors, backpressure and mid-flight reset, plus a double-precision
// instance swept against the real exp().
`timescale 1ns/1ps
module tb_float_exp_interp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int delivered = 0;
    int issued    = 0;

    // Single-precision DUT
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, c;
`ifdef FLOAT_EXP_FLAGS_EN
    logic [2:0]  flags, d_flags;
`endif

    float_exp_interp_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .out_valid(out_valid), .out_ready(out_ready), .c(c)
`ifdef FLOAT_EXP_FLAGS_EN
        , .flags(flags)
`endif
    );

    // Double-precision DUT
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [63:0] d_a, d_c;

    float_exp_interp_pipe #(.EXP_BITS(11), .MAN_BITS(52), .STEPS(256)) dut_dbl (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .out_valid(d_out_valid), .out_ready(d_out_ready), .c(d_c)
`ifdef FLOAT_EXP_FLAGS_EN
        , .flags(d_flags)
`endif
    );

    typedef struct {
        logic [31:0] want;
        int          tol;
        int          issue;
        bit          lat;
        logic [2:0]  fl;
        string       name;
    } exp_t;

    exp_t sb[$];
    real  d_q[$];

    task automatic check(input string name, input bit ok, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Single-precision monitor: stall behaviour and in-order scoreboard pops.
    logic        hold_prev = 1'b0;
    logic [31:0] c_prev = '0;
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] diff;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_valid_held", out_valid == 1'b1, 64'(out_valid), 64'd1);
                check("stall_c_held", c == c_prev, 64'(c), 64'(c_prev));
            end
            if (out_valid && !out_ready)
                check("stall_in_ready_low", in_ready == 1'b0, 64'(in_ready), 64'd0);
            hold_prev = out_valid && !out_ready;
            c_prev    = c;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1'b0, 64'(c), 64'd0);
                end else begin
                    e    = sb.pop_front();
                    diff = (c > e.want) ? c - e.want : e.want - c;
                    check(e.name, diff <= 32'(e.tol), 64'(c), 64'(e.want));
                    if (e.lat)
                        check({e.name, "_latency"}, (cyc - e.issue) == 6, 64'(cyc - e.issue), 64'd6);
`ifdef FLOAT_EXP_FLAGS_EN
                    check({e.name, "_flags"}, flags == e.fl, 64'(flags), 64'(e.fl));
`endif
                    delivered++;
                end
            end
        end
    end

    // Double-precision monitor: relative error against $exp.
    always @(negedge clk) begin
        real got, want, rel;
        if (rst_n && d_out_valid) begin
            if (d_q.size() == 0) begin
                check("dbl_unexpected_output", 1'b0, d_c, 64'd0);
            end else begin
                want = d_q.pop_front();
                got  = $bitstoreal(d_c);
                rel  = (got - want) / want;
                if (rel < 0.0) rel = -rel;
                check("dbl_relerr", rel <= 2.0 ** (-18), d_c, $realtobits(want));
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [31:0] want, input int tol,
                        input bit lat, input logic [2:0] fl, input string name);
        exp_t e;
        bit   done = 1'b0;
        in_valid = 1'b1;
        a        = v;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e = '{want: want, tol: tol, issue: cyc, lat: lat, fl: fl, name: name};
                sb.push_back(e);
                issued++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check({name, "_accept_timeout"}, 1'b0, 64'd0, 64'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check({name, "_drain_timeout"}, 1'b0, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] st_a    [10];
    logic [31:0] st_want [10];
    int          st_tol  [10];
    logic [2:0]  st_fl   [10];

    initial begin
        st_a    = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h40000000, 32'h3F000000,
                    32'hBF000000, 32'h7F800000, 32'hFF800000, 32'h41100000, 32'h00000001};
        st_want = '{32'h3F800000, 32'h402DF854, 32'h3EBC5AB2, 32'h40EC7326, 32'h3FD3094C,
                    32'h3F1B4597, 32'h7F800000, 32'h00000000, 32'h7F800000, 32'h3F800000};
        st_tol  = '{0, 'h100, 'h100, 'h100, 'h100, 'h100, 0, 0, 0, 0};
        st_fl   = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; out_ready = 1'b1;
        d_in_valid = 1'b0; d_a = '0; d_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        check("reset_c", c == 32'd0, 64'(c), 64'd0);
        check("reset_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed single-precision vectors
        send(32'h00000000, 32'h3F800000, 0, 1'b1, 3'b000, "zero_exact");
        drain("zero");
        send(32'h3F800000, 32'h402DF854, 'h100, 1'b0, 3'b000, "exp_pos1");
        send(32'hBF800000, 32'h3EBC5AB2, 'h100, 1'b0, 3'b000, "exp_neg1");
        send(32'h41100000, 32'h7F800000, 0, 1'b0, 3'b010, "pos9_overflow");
        send(32'hC1100000, 32'h00000000, 0, 1'b0, 3'b001, "neg9_underflow");
        send(32'h7FC00001, 32'h7FC00000, 0, 1'b0, 3'b100, "nan_canonical");
        drain("directed");

        // Ten back-to-back items with out_ready dropped for three cycles
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(st_a[i], st_want[i], st_tol[i], 1'b0, st_fl[i], $sformatf("stream%0d", i));
            end
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stream");
        check("stream_delivered", delivered == issued, 64'(delivered), 64'(issued));

        // Reset pulse with four items in flight
        for (int i = 0; i < 4; i++)
            send(st_a[i + 1], st_want[i + 1], st_tol[i + 1], 1'b0, 3'b000, "flushed");
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_flush_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        send(32'h3F000000, 32'h3FD3094C, 'h100, 1'b1, 3'b000, "post_reset");
        drain("post_reset");

        // Double-precision sweep over [-8, 8] in steps of 1/16
        for (int n = 0; n <= 256; n++) begin
            real x;
            x = -8.0 + real'(n) / 16.0;
            d_in_valid = 1'b1;
            d_a = $realtobits(x);
            @(negedge clk);
            if (d_in_ready) d_q.push_back($exp(x));
            else check("dbl_in_ready", 1'b0, 64'(d_in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        d_in_valid = 1'b0;
        for (int n = 0; n < 50 && d_q.size() != 0; n++) @(posedge clk);
        if (d_q.size() != 0) check("dbl_drain_timeout", 1'b0, 64'(d_q.size()), 64'd0);
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
